// File: rtl/exu_pkg.sv
// Shared types and default parameters for the execution-unit dispatcher.
package exu_pkg;

   localparam int         CHN_NUM_DEF = 5;
   localparam logic [4:0] MC_MASK_DEF = 5'b00110;
   localparam int         TMO_CYC_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DRAIN
   } exu_disp_st_e;

   // Counter width able to hold max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/exu_disp_tmo.sv
// Saturating cycle counter for WAIT/DRAIN; flags the cycle on which the limit is reached.
module exu_disp_tmo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: next-state gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // The current cycle counts toward the limit, so expiry lands on the limit-th cycle.
   assign expired = enable && (limit != '0) &&
                    (({1'b0, cnt_q} + (W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/exu_dispatch.sv
// Dispatches one instruction at a time to a one-hot selected execution channel,
// tracking multi-cycle completion, flush drain and timeout.
module exu_dispatch import exu_pkg::*; #(
   parameter int                 CHN_NUM = CHN_NUM_DEF,
   parameter logic [CHN_NUM-1:0] MC_MASK = CHN_NUM'(MC_MASK_DEF),
   parameter int                 TMO_CYC = TMO_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_vld,
   input  logic [CHN_NUM-1:0] req_cls,
   output logic               req_rdy,
   input  logic               fl_vld,
   output logic [CHN_NUM-1:0] chn_sel,
   input  logic [CHN_NUM-1:0] chn_rdy,
   input  logic [CHN_NUM-1:0] chn_done,
   output logic [CHN_NUM-1:0] chn_kill,
   output logic               busy,
   output logic [31:0]        retire_cnt,
   output logic               err_ill,
   output logic               err_tmo
);

   localparam int IDX_W = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;
   localparam int TMR_W = cnt_width(TMO_CYC);

   exu_disp_st_e       state_q, state_d;
   logic [IDX_W-1:0]   cur_q, cur_d, req_idx;
   logic [31:0]        retire_q, retire_d;
   logic [CHN_NUM-1:0] cur_oh, sel_c, kill_c;
   logic               req_onehot, cur_done, tmo_expired;
   logic               rdy_c, ill_c, tmo_c;

   assign req_onehot = (req_cls != '0) && ((req_cls & (req_cls - CHN_NUM'(1))) == '0);
   assign cur_oh     = CHN_NUM'(1) << cur_q;
   assign cur_done   = |(chn_done & cur_oh);

   always_comb begin
      req_idx = '0;
      for (int c = 0; c < CHN_NUM; c++)
         if (req_cls[c]) req_idx = IDX_W'(c);
   end

   exu_disp_tmo #(.W(TMR_W)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q == ST_IDLE),
      .enable  (state_q != ST_IDLE),
      .limit   (TMR_W'(TMO_CYC)),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      retire_d = retire_q;
      sel_c    = '0;
      kill_c   = '0;
      rdy_c    = 1'b0;
      ill_c    = 1'b0;
      tmo_c    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fl_vld) begin
               rdy_c = 1'b1;
            end else if (req_vld) begin
               if (!req_onehot) begin
                  rdy_c = 1'b1;
                  ill_c = 1'b1;
               end else begin
                  sel_c = req_cls;
                  if (|(req_cls & chn_rdy)) begin
                     if (|(req_cls & MC_MASK)) begin
                        cur_d   = req_idx;
                        state_d = ST_WAIT;
                     end else begin
                        rdy_c    = 1'b1;
                        retire_d = retire_q + 32'd1;
                     end
                  end
               end
            end
         end
         ST_WAIT: begin
            // Flush beats completion; completion beats a same-cycle timeout.
            sel_c = cur_oh;
            if (fl_vld) begin
               sel_c   = '0;
               rdy_c   = 1'b1;
               kill_c  = cur_oh;
               state_d = ST_DRAIN;
            end else if (cur_done) begin
               rdy_c    = 1'b1;
               retire_d = retire_q + 32'd1;
               state_d  = ST_IDLE;
            end else if (tmo_expired) begin
               sel_c   = '0;
               rdy_c   = 1'b1;
               tmo_c   = 1'b1;
               kill_c  = cur_oh;
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (cur_done) begin
               state_d = ST_IDLE;
            end else if (tmo_expired) begin
               tmo_c   = 1'b1;
               kill_c  = cur_oh;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cur_q    <= '0;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         retire_q <= retire_d;
      end
   end

   // Combinational outputs are masked so that everything reads 0 while reset is held.
   assign chn_sel    = rst ? '0 : sel_c;
   assign chn_kill   = rst ? '0 : kill_c;
   assign req_rdy    = !rst && rdy_c;
   assign err_ill    = !rst && ill_c;
   assign err_tmo    = !rst && tmo_c;
   assign busy       = !rst && (state_q != ST_IDLE);
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_exu_dispatch.sv
// Self-checking bench for exu_dispatch: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_exu_dispatch;

   localparam int         TMO = 4;
   localparam logic [4:0] MC  = 5'b00110;

   logic        clk, rst;
   logic        req_vld, fl_vld, req_rdy, busy, err_ill, err_tmo;
   logic [4:0]  req_cls, chn_sel, chn_rdy, chn_done, chn_kill;
   logic [31:0] retire_cnt;

   int n_checks = 0;
   int n_err    = 0;

   // Model: is an instruction outstanding, has it been flushed, which channel,
   // how many cycles it has spent outstanding, and how many have retired.
   bit          m_out, m_flushed;
   int          m_ch, m_age;
   logic [31:0] m_retired;

   exu_dispatch #(.CHN_NUM(5), .MC_MASK(MC), .TMO_CYC(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_vld    (req_vld),
      .req_cls    (req_cls),
      .req_rdy    (req_rdy),
      .fl_vld     (fl_vld),
      .chn_sel    (chn_sel),
      .chn_rdy    (chn_rdy),
      .chn_done   (chn_done),
      .chn_kill   (chn_kill),
      .busy       (busy),
      .retire_cnt (retire_cnt),
      .err_ill    (err_ill),
      .err_tmo    (err_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // Model evaluated mid-cycle, once inputs are stable; it also advances the model.
   always @(negedge clk) begin
      logic [4:0]  e_sel, e_kill;
      logic        e_rdy, e_ill, e_tmo, e_busy;
      logic [31:0] e_cnt;
      int          ch, elapsed;
      e_sel = '0; e_kill = '0; e_rdy = 0; e_ill = 0; e_tmo = 0;
      e_busy = m_out; e_cnt = m_retired;
      if (rst) begin
         e_busy = 0; e_cnt = '0;
         m_out = 0; m_flushed = 0; m_ch = 0; m_age = 0; m_retired = '0;
      end else if (!m_out) begin
         if (fl_vld) e_rdy = 1;
         else if (req_vld) begin
            if ($countones(req_cls) != 1) begin
               e_rdy = 1; e_ill = 1;
            end else begin
               e_sel = req_cls;
               ch = 0;
               for (int i = 0; i < 5; i++) if (req_cls[i]) ch = i;
               if (chn_rdy[ch]) begin
                  if (MC[ch]) begin
                     m_out = 1; m_flushed = 0; m_ch = ch; m_age = 0;
                  end else begin
                     e_rdy = 1; m_retired = m_retired + 1;
                  end
               end
            end
         end
      end else begin
         elapsed = m_age + 1;
         m_age   = elapsed;
         if (!m_flushed) begin
            if (fl_vld) begin
               e_rdy = 1; e_kill = 5'(1 << m_ch); m_flushed = 1;
            end else if (chn_done[m_ch]) begin
               e_sel = 5'(1 << m_ch); e_rdy = 1; m_out = 0; m_retired = m_retired + 1;
            end else if (elapsed >= TMO) begin
               e_rdy = 1; e_tmo = 1; e_kill = 5'(1 << m_ch); m_out = 0;
            end else begin
               e_sel = 5'(1 << m_ch);
            end
         end else begin
            if (chn_done[m_ch]) m_out = 0;
            else if (elapsed >= TMO) begin
               e_tmo = 1; e_kill = 5'(1 << m_ch); m_out = 0;
            end
         end
      end
      check("chn_sel",    chn_sel,    e_sel);
      check("chn_kill",   chn_kill,   e_kill);
      check("req_rdy",    req_rdy,    e_rdy);
      check("err_ill",    err_ill,    e_ill);
      check("err_tmo",    err_tmo,    e_tmo);
      check("busy",       busy,       e_busy);
      check("retire_cnt", retire_cnt, e_cnt);
   end

   task automatic drive(input logic v, input logic [4:0] cls, input logic [4:0] rdy,
                        input logic [4:0] dn, input logic fl);
      req_vld = v; req_cls = cls; chn_rdy = rdy; chn_done = dn; fl_vld = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 5'b0, 5'b0, 5'b0, 0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) tick();
      check("reset_busy", busy, 0);
      check("reset_cnt",  retire_cnt, 0);
      rst = 1'b0;

      // Single-cycle channel 0 retires in the accept cycle.
      drive(1, 5'b00001, 5'b00001, 5'b0, 0); #2;
      check("sc_rdy", req_rdy, 1);
      check("sc_sel", chn_sel, 5'b00001);
      tick();
      check("sc_cnt", retire_cnt, 1);
      check("sc_model_cnt", m_retired, 1);
      check("sc_busy", busy, 0);

      // Channel not ready: select held, no retire.
      drive(1, 5'b00001, 5'b11110, 5'b0, 0); #2;
      check("hold_sel", chn_sel, 5'b00001);
      check("hold_rdy", req_rdy, 0);
      tick();

      // Multi-cycle channel 1 done three cycles after accept; foreign done ignored.
      drive(1, 5'b00010, 5'b00010, 5'b0, 0); #2;
      check("mc_acc_rdy", req_rdy, 0);
      tick();
      idle(); #2; check("mc_busy1", busy, 1); tick();
      drive(0, 5'b0, 5'b0, 5'b00100, 0); #2; check("mc_busy2", busy, 1); tick();
      drive(0, 5'b0, 5'b0, 5'b00010, 0); #2;
      check("mc_busy3", busy, 1);
      check("mc_done_rdy", req_rdy, 1);
      tick();
      check("mc_idle", busy, 0);
      check("mc_cnt", retire_cnt, 2);

      // Illegal classes, then done in IDLE ignored.
      drive(1, 5'b00011, 5'b11111, 5'b0, 0); #2;
      check("ill_multi", err_ill, 1);
      check("ill_multi_sel", chn_sel, 0);
      tick();
      drive(1, 5'b00000, 5'b11111, 5'b0, 0); #2;
      check("ill_zero", err_ill, 1);
      check("ill_zero_rdy", req_rdy, 1);
      tick();
      drive(0, 5'b0, 5'b0, 5'b11111, 0); tick();
      check("ill_cnt", retire_cnt, 2);
      check("ill_busy", busy, 0);

      // Flush together with done on channel 2, then drain.
      drive(1, 5'b00100, 5'b00100, 5'b0, 0); tick();
      idle(); tick();
      drive(0, 5'b0, 5'b0, 5'b00100, 1); #2;
      check("fl_kill", chn_kill, 5'b00100);
      check("fl_rdy",  req_rdy, 1);
      check("fl_sel",  chn_sel, 0);
      tick();
      idle(); #2;
      check("drain_busy", busy, 1);
      check("drain_kill", chn_kill, 0);
      tick();
      drive(0, 5'b0, 5'b0, 5'b00100, 0); tick();
      check("drain_idle", busy, 0);
      check("drain_cnt", retire_cnt, 2);

      // Timeout on channel 1: fires on the fourth cycle after accept.
      drive(1, 5'b00010, 5'b00010, 5'b0, 0); tick();
      idle();
      for (int k = 1; k < TMO; k++) begin
         #2; check("tmo_early", err_tmo, 0); tick();
      end
      #2;
      check("tmo_pulse", err_tmo, 1);
      check("tmo_kill",  chn_kill, 5'b00010);
      check("tmo_rdy",   req_rdy, 1);
      tick();
      check("tmo_idle", busy, 0);
      check("tmo_cnt",  retire_cnt, 2);

      // Counter wrap from all ones.
      force dut.retire_q = 32'hFFFF_FFFF;
      m_retired = 32'hFFFF_FFFF;
      #1 release dut.retire_q;
      drive(1, 5'b00001, 5'b00001, 5'b0, 0); #1;
      check("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
      tick();
      check("wrap_cnt", retire_cnt, 0);
      check("wrap_model", m_retired, 0);

      // Reset asserted mid-WAIT clears every output at once, no kill pulse.
      drive(1, 5'b00100, 5'b00100, 5'b0, 0); tick();
      drive(1, 5'b00001, 5'b11111, 5'b11111, 0);
      #1 rst = 1'b1;
      #1;
      check("rst_sel",  chn_sel, 0);
      check("rst_kill", chn_kill, 0);
      check("rst_rdy",  req_rdy, 0);
      check("rst_busy", busy, 0);
      check("rst_ill",  err_ill, 0);
      check("rst_tmo",  err_tmo, 0);
      tick();
      rst = 1'b0;
      idle();

      // Randomized traffic, checked every cycle by the model.
      for (int n = 0; n < 4000; n++) begin
         logic [4:0] cls;
         if (($urandom % 10) < 8) cls = 5'(1 << ($urandom % 5));
         else                     cls = 5'($urandom);
         drive(($urandom % 10) < 7, cls, 5'($urandom),
               5'($urandom) & 5'($urandom), ($urandom % 20) == 0);
         rst = (($urandom % 300) == 0);
         tick();
      end
      rst = 1'b0;
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/exu_dispatch.md
EXU_DISPATCH -- requirements
Module: exu_dispatch

Interface
REQ-001 SHALL have parameter CHN_NUM, default 5: number of execution channels.
REQ-002 SHALL have parameter MC_MASK [CHN_NUM-1:0], default 5'b00110: bit c set means channel c is multi-cycle (completes on chn_done); clear means it completes on accept.
REQ-003 SHALL have parameter TMO_CYC, default 255: WAIT/DRAIN timeout in cycles; 0 disables the timeout.
REQ-004 Port list; clock and reset come first. One clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_vld  in  1  instruction present.
- req_cls  in  CHN_NUM  one-hot target channel.
- req_rdy  out  1  instruction retired or dropped this cycle.
- fl_vld  in  1  pipeline flush.
- chn_sel  out  CHN_NUM  channel select; at most one bit set.
- chn_rdy  in  CHN_NUM  channel accepted its select.
- chn_done  in  CHN_NUM  multi-cycle channel completion pulse.
- chn_kill  out  CHN_NUM  one-cycle abort pulse to a channel.
- busy  out  1  state is not IDLE.
- retire_cnt  out  32  retired-instruction count.
- err_ill  out  1  illegal-class pulse.
- err_tmo  out  1  timeout pulse.

Function
REQ-005 SHALL implement the states IDLE, WAIT and DRAIN, and SHALL latch the channel index cur into a register of width $clog2(CHN_NUM).
REQ-006 IDLE with fl_vld=1: req_rdy=1, chn_sel=0, and the state stays IDLE; fl_vld has priority over req_vld.
REQ-007 IDLE with req_vld=1 and req_cls not one-hot (zero or multi-hot): req_rdy=1 and err_ill=1 for one cycle, chn_sel=0, and the instruction is dropped.
REQ-008 IDLE with a legal req_vld: chn_sel=req_cls combinationally, in the same cycle.
REQ-009 Single-cycle channel c with chn_rdy[c]=1: req_rdy=1 in that cycle, retire_cnt increments at the next edge, and the state stays IDLE.
REQ-010 Multi-cycle channel c with chn_rdy[c]=1: req_rdy=0, cur latches c, the timer clears, and the state goes to WAIT.
REQ-011 If chn_rdy[c]=0, the block SHALL hold chn_sel with req_rdy=0.
REQ-012 WAIT: chn_sel[cur]=1 held; on chn_done[cur], req_rdy=1, retire_cnt increments, and the state goes to IDLE.
REQ-013 WAIT with fl_vld=1: fl_vld has priority over a same-cycle chn_done. The block SHALL drive req_rdy=1 and chn_kill[cur]=1 for one cycle, drop chn_sel, not increment retire_cnt, and move to DRAIN.
REQ-014 DRAIN: chn_sel=0 and req_rdy=0; on chn_done[cur] the state goes to IDLE with no retire.
REQ-015 Timer SHALL count cycles spent in WAIT/DRAIN, saturating, with width $clog2(TMO_CYC+1).
REQ-016 When the timer reaches TMO_CYC (with TMO_CYC>0): err_tmo=1 and chn_kill[cur]=1 for one cycle, and the state goes to IDLE. If the timeout occurs in WAIT, req_rdy=1 that cycle (instruction dropped).
REQ-017 chn_done[c] for c!=cur, or chn_done received in IDLE, SHALL be ignored.
REQ-018 retire_cnt SHALL wrap from 2^32-1 to 0.
REQ-019 err_ill, err_tmo and chn_kill SHALL be single-cycle pulses and never held.

Reset
REQ-020 While rst=1: state=IDLE, cur=0, timer=0, retire_cnt=0.
REQ-021 During reset, chn_sel, chn_kill, req_rdy, busy, err_ill and err_tmo SHALL all read 0.
REQ-022 Reset asserted mid-WAIT SHALL abandon the instruction without a chn_kill pulse; the channels are reset by the same rst.

Structure
REQ-023 Package exu_pkg SHALL hold the state enum exu_disp_st_e and the default CHN_NUM, MC_MASK and TMO_CYC constants.
REQ-024 The timeout counter SHALL be the sub-module exu_disp_tmo, with inputs clear, enable and limit and a single output, expired.
REQ-025 One-hot checking and index encoding SHALL be combinational logic inside exu_dispatch.

Verification
REQ-026 req_cls=5'b00001, chn_rdy[0]=1 -> req_rdy=1 in the same cycle, retire_cnt=1, busy stays 0.
REQ-027 req_cls=5'b00010, chn_done[1] three cycles after accept -> busy=1 for 3 cycles, req_rdy=1 on the done cycle, retire_cnt increments by 1.
REQ-028 req_cls=5'b00011, then 5'b00000 -> err_ill pulses each time, req_rdy=1, chn_sel=0, retire_cnt unchanged.
REQ-029 Multi-cycle channel 2 in WAIT, fl_vld together with chn_done[2] in the same cycle -> chn_kill[2]=1, state DRAIN, no retire; a later chn_done[2] returns the block to IDLE.
REQ-030 TMO_CYC=4, multi-cycle channel 1 never sends done -> err_tmo and chn_kill[1] pulse 4 cycles after accept, req_rdy=1, state IDLE.
REQ-031 retire_cnt preloaded via force to 32'hFFFFFFFF plus one retire -> reads 0; rst asserted mid-WAIT -> all outputs 0 asynchronously.
